avalon_copy_master: RTL and testbench



---
 rtl/avalon_copy_master_pkg.sv | 16 +
 rtl/avalon_copy_master_if.sv | 41 ++++
 rtl/avalon_copy_master_fifo.sv | 66 ++++++
 rtl/avalon_copy_master.sv | 211 +++++++++++++++++++++
 tb/tb_avalon_copy_master.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_copy_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : avalon_copy_master_pkg
// Description : Shared state encodings and defaults for the copy master.
// Revision    : 1.0 - initial release
// ============================================================================
package avalon_copy_master_pkg;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_flush = 2'd2;

    localparam int c_addr_step_default = 4;

endpackage
`default_nettype wire

// File: rtl/avalon_copy_master_if.sv
`default_nettype none
// ============================================================================
// Module      : avalon_copy_master_if
// Description : Request/response bus between the copy master and the bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface avalon_copy_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0] master_address;
    logic                  master_ready;
    logic [DATA_WIDTH-1:0] master_write_data;
    logic                  master_write_req;
    logic                  master_read_req;
    logic [DATA_WIDTH-1:0] master_read_data;
    logic                  master_read_data_valid;

    modport master (
        output master_address,
        output master_write_data,
        output master_write_req,
        output master_read_req,
        input  master_ready,
        input  master_read_data,
        input  master_read_data_valid
    );

    modport slave (
        input  master_address,
        input  master_write_data,
        input  master_write_req,
        input  master_read_req,
        output master_ready,
        output master_read_data,
        output master_read_data_valid
    );

endinterface
`default_nettype wire

// File: rtl/avalon_copy_master_fifo.sv
`default_nettype none
// ============================================================================
// Module      : avalon_copy_fifo
// Description : Show-ahead synchronous FIFO buffering returned read data.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_copy_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_push,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_pop,
    output logic [DATA_WIDTH-1:0]   o_head,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_empty
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_full  = (c_ptr_w + 1)'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_one   = c_ptr_w'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_ptr_w:0]      r_count;
    logic                  w_push;
    logic                  w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && (r_count != c_full);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/avalon_copy_master.sv
`default_nettype none
// ============================================================================
// Module      : avalon_copy_master
// Description : Copies LEN words from SRC to DST with pipelined reads.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_copy_master
    import avalon_copy_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_STEP  = c_addr_step_default
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    avalon_copy_master_if.master  bus
);

    localparam int                    c_cnt_w = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] c_step  = ADDR_WIDTH'(ADDR_STEP);
    localparam logic [c_cnt_w:0]      c_depth = (c_cnt_w + 1)'(FIFO_DEPTH);
    localparam logic [LEN_WIDTH-1:0]  c_len_one = LEN_WIDTH'(1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_src_ptr;
    logic [ADDR_WIDTH-1:0] r_dst_ptr;
    logic [LEN_WIDTH-1:0]  r_rd_left;
    logic [LEN_WIDTH-1:0]  r_wr_left;
    logic [c_cnt_w-1:0]    r_outstanding;
    logic                  r_read_req;
    logic                  r_write_req;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0] r_write_data;

    logic [DATA_WIDTH-1:0] w_fifo_head;
    logic [c_cnt_w-1:0]    w_fifo_count;
    logic                  w_fifo_empty;
    logic                  w_fifo_push;
    logic                  w_fifo_pop;

    logic                  w_req_pending;
    logic                  w_accept;
    logic                  w_can_load;
    logic                  w_rd_valid;
    logic                  w_wr_avail;
    logic [c_cnt_w:0]      w_occupancy;
    logic                  w_credit;
    logic                  w_launch;
    logic                  w_last_write;
    logic                  w_load_write;
    logic                  w_load_read;
    logic                  w_bypass;
    logic                  w_issue_read;

    avalon_copy_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_fifo_push),
        .i_data  (bus.master_read_data),
        .i_pop   (w_fifo_pop),
        .o_head  (w_fifo_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    assign w_req_pending = r_read_req | r_write_req;
    assign w_accept      = w_req_pending & bus.master_ready;
    assign w_can_load    = !w_req_pending || bus.master_ready;
    // Strobes with nothing in flight are stray and must not touch the FIFO.
    assign w_rd_valid    = bus.master_read_data_valid && (r_outstanding != '0);
    assign w_wr_avail    = !w_fifo_empty || w_rd_valid;

    // Every word the engine is responsible for (in flight, buffered, or held
    // in the write register) is counted, so the FIFO can never overflow.
    assign w_occupancy = {1'b0, w_fifo_count} + {1'b0, r_outstanding}
                       + {{c_cnt_w{1'b0}}, r_write_req};
    assign w_credit    = (w_occupancy < c_depth);

    assign w_launch     = (r_state == c_st_idle) && start && (len != '0);
    assign w_last_write = r_write_req && bus.master_ready && (r_wr_left == '0);

    always_comb begin
        w_load_write = 1'b0;
        w_load_read  = 1'b0;
        w_bypass     = 1'b0;
        if ((r_state == c_st_run) && w_can_load) begin
            if (w_wr_avail && (r_wr_left != '0)) begin
                w_load_write = 1'b1;
                // Data arriving into an empty FIFO goes straight to the bus.
                w_bypass     = w_fifo_empty;
            end else if ((r_rd_left != '0) && w_credit) begin
                w_load_read  = 1'b1;
            end
        end
    end

    assign w_fifo_push  = w_rd_valid && !w_bypass;
    assign w_fifo_pop   = w_load_write && !w_bypass;
    assign w_issue_read = w_launch || w_load_read;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_nxt = (len != '0) ? c_st_run : c_st_flush;
                end
            end
            c_st_run: begin
                if (w_last_write) begin
                    w_state_nxt = c_st_flush;
                end
            end
            c_st_flush: w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // Status outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_st_run:   busy = 1'b1;
            c_st_flush: done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Pointers, counters and the request register. Pointers and remaining
    // counts advance when a request is loaded, so selection never needs
    // look-ahead values at the accepting edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_src_ptr     <= '0;
            r_dst_ptr     <= '0;
            r_rd_left     <= '0;
            r_wr_left     <= '0;
            r_outstanding <= '0;
            r_read_req    <= 1'b0;
            r_write_req   <= 1'b0;
            r_address     <= '0;
            r_write_data  <= '0;
        end else begin
            case ({w_issue_read, w_rd_valid})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase

            if (w_launch) begin
                r_read_req  <= 1'b1;
                r_write_req <= 1'b0;
                r_address   <= src_addr;
                r_src_ptr   <= src_addr + c_step;
                r_dst_ptr   <= dst_addr;
                r_rd_left   <= len - c_len_one;
                r_wr_left   <= len;
            end else if (w_load_write) begin
                r_read_req   <= 1'b0;
                r_write_req  <= 1'b1;
                r_address    <= r_dst_ptr;
                r_write_data <= w_bypass ? bus.master_read_data : w_fifo_head;
                r_dst_ptr    <= r_dst_ptr + c_step;
                r_wr_left    <= r_wr_left - c_len_one;
            end else if (w_load_read) begin
                r_read_req  <= 1'b1;
                r_write_req <= 1'b0;
                r_address   <= r_src_ptr;
                r_src_ptr   <= r_src_ptr + c_step;
                r_rd_left   <= r_rd_left - c_len_one;
            end else if (w_accept) begin
                r_read_req  <= 1'b0;
                r_write_req <= 1'b0;
            end
        end
    end

    assign bus.master_read_req   = r_read_req;
    assign bus.master_write_req  = r_write_req;
    assign bus.master_address    = r_address;
    assign bus.master_write_data = r_write_data;

endmodule
`default_nettype wire

// File: tb/tb_avalon_copy_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_copy_master
// Description : Scoreboard bench with a memory-slave model for the copy master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_copy_master;

    localparam int c_depth = 8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;

    avalon_copy_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    avalon_copy_master #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .LEN_WIDTH  (16),
        .FIFO_DEPTH (c_depth),
        .ADDR_STEP  (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Expected traffic, pushed by stimulus and popped by the monitor
    logic [31:0] exp_rd[$];
    logic [31:0] exp_wa[$];
    logic [31:0] exp_wd[$];
    // Slave response pipeline
    int          resp_due[$];
    logic [31:0] resp_dat[$];

    int lat = 1;
    int rdy_pct = 100;
    int spur = 0;
    int rd_acc = 0, wr_acc = 0;
    int done_cnt = 0, done_cyc = -1, req_seen = 0, busy_seen = 0;
    int first_rd = -1, first_wr = -1;
    logic        hold_prev = 1'b0;
    logic [65:0] prev_bundle = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory contents seen by the slave
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'h1000;
        if (off < 32'h10) return 32'hA0 + (off >> 2);
        return (a * 32'h9E3779B1) + 32'h7;
    endfunction

    always @(posedge clk) cyc++;

    // Slave + monitor: drives ready/response for the coming edge, then
    // checks whatever will be accepted on that edge.
    always @(negedge clk) begin
        logic acc_rd, acc_wr;
        logic [65:0] bundle;
        bundle = {bus.master_read_req, bus.master_write_req,
                  bus.master_address, bus.master_write_data};
        if (rst_n && hold_prev) chk("hold_stable", 64'(bundle ^ prev_bundle), 64'd0);
        if (!rst_n) begin
            resp_due.delete();
            resp_dat.delete();
            rd_acc = 0;
            wr_acc = 0;
            hold_prev = 1'b0;
            bus.master_ready = 1'b0;
            bus.master_read_data_valid = 1'b0;
        end else begin
            if (resp_due.size() > 0 && resp_due[0] == cyc) begin
                bus.master_read_data_valid = 1'b1;
                bus.master_read_data = resp_dat.pop_front();
                void'(resp_due.pop_front());
            end else if (spur != 0) begin
                bus.master_read_data_valid = 1'b1;
                bus.master_read_data = 32'hDEADBEEF;
            end else begin
                bus.master_read_data_valid = 1'b0;
            end
            bus.master_ready = ($urandom_range(99) < rdy_pct);
            if (busy) busy_seen++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (bus.master_read_req || bus.master_write_req) begin
                req_seen++;
                chk("req_exclusive", 64'(bus.master_read_req & bus.master_write_req), 64'd0);
            end
            acc_rd = bus.master_read_req && bus.master_ready;
            acc_wr = bus.master_write_req && bus.master_ready;
            if (acc_rd) begin
                if (first_rd < 0) first_rd = cyc;
                rd_acc++;
                resp_due.push_back(cyc + lat);
                resp_dat.push_back(mem_fn(bus.master_address));
                if (exp_rd.size() == 0) chk("rd_extra", 64'd1, 64'd0);
                else chk("rd_addr", 64'(bus.master_address), 64'(exp_rd.pop_front()));
                chk("inflight_le_depth", 64'(rd_acc - wr_acc <= c_depth), 64'd1);
            end
            if (acc_wr) begin
                if (first_wr < 0) first_wr = cyc;
                wr_acc++;
                if (exp_wa.size() == 0) chk("wr_extra", 64'd1, 64'd0);
                else begin
                    chk("wr_addr", 64'(bus.master_address), 64'(exp_wa.pop_front()));
                    chk("wr_data", 64'(bus.master_write_data), 64'(exp_wd.pop_front()));
                end
            end
            hold_prev = (bus.master_read_req || bus.master_write_req) && !bus.master_ready;
            prev_bundle = bundle;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int start_cyc;

    task automatic start_copy(input logic [31:0] s, input logic [31:0] d,
                              input int n, input int l, input int rp);
        logic [31:0] a;
        lat = l;
        rdy_pct = rp;
        for (int i = 0; i < n; i++) begin
            a = s + 32'(4 * i);
            exp_rd.push_back(a);
            exp_wa.push_back(d + 32'(4 * i));
            exp_wd.push_back(mem_fn(a));
        end
        done_cnt = 0; done_cyc = -1; req_seen = 0; busy_seen = 0;
        first_rd = -1; first_wr = -1;
        start = 1'b1; src_addr = s; dst_addr = d; len = 16'(n);
        start_cyc = cyc;
        tick();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(n != 0));
    endtask

    task automatic finish_copy(input int restart_at);
        int k;
        for (k = 0; k < 3000 && done_cnt == 0; k++) begin
            if (k == restart_at) begin
                start = 1'b1; src_addr = 32'h5555_0000; dst_addr = 32'h6666_0000; len = 16'd3;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        if (done_cnt == 0) chk("done_timeout", 64'd0, 64'd1);
        repeat (4) tick();
        chk("done_once", 64'(done_cnt), 64'd1);
        chk("busy_low_after", 64'(busy), 64'd0);
        chk("all_reads_seen", 64'(exp_rd.size()), 64'd0);
        chk("all_writes_seen", 64'(exp_wa.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        bus.master_ready = 1'b0;
        bus.master_read_data_valid = 1'b0;
        bus.master_read_data = '0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_reqs", 64'({bus.master_read_req, bus.master_write_req}), 64'd0);
        chk("rst_addr", 64'(bus.master_address), 64'd0);
        chk("rst_wdata", 64'(bus.master_write_data), 64'd0);
        rst_n = 1'b1;
        tick();

        // Stray read strobes while idle must be ignored
        spur = 1;
        repeat (3) tick();
        spur = 0;
        tick();

        // Basic copy
        start_copy(32'h1000, 32'h2000, 4, 2, 100);
        finish_copy(-1);

        // Zero length
        start_copy(32'h1000, 32'h2000, 0, 2, 100);
        finish_copy(-1);
        chk("len0_done_cycle", 64'(done_cyc), 64'(start_cyc + 1));
        chk("len0_no_reqs", 64'(req_seen), 64'd0);
        chk("len0_no_busy", 64'(busy_seen), 64'd0);

        // Minimum latency, len=1, L=1
        start_copy(32'h3000, 32'h4000, 1, 1, 100);
        finish_copy(-1);
        chk("lat_read", 64'(first_rd), 64'(start_cyc + 1));
        chk("lat_write", 64'(first_wr), 64'(start_cyc + 3));
        chk("lat_done", 64'(done_cyc), 64'(start_cyc + 4));

        // Long latency, credit limit
        start_copy(32'h0001_0000, 32'h0002_0000, 20, 10, 100);
        finish_copy(-1);

        // Random backpressure
        start_copy(32'h0003_0000, 32'h0004_0000, 6, 2, 50);
        finish_copy(-1);

        // Address wrap-around plus ignored second start
        start_copy(32'hFFFF_FFF8, 32'h0005_0000, 4, 3, 100);
        finish_copy(3);

        // Reset after two writes of a len=8 copy
        start_copy(32'h0006_0000, 32'h0007_0000, 8, 2, 100);
        for (int k = 0; k < 500 && wr_acc < 2; k++) tick();
        chk("reached_two_writes", 64'(wr_acc >= 2), 64'd1);
        rst_n = 1'b0;
        tick();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_reqs", 64'({bus.master_read_req, bus.master_write_req}), 64'd0);
        rst_n = 1'b1;
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        done_cnt = 0;
        repeat (5) tick();
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        start_copy(32'h0008_0000, 32'h0009_0000, 8, 2, 100);
        finish_copy(-1);

        // Randomized copies
        for (int t = 0; t < 4; t++) begin
            start_copy($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                       int'($urandom_range(12, 1)), int'($urandom_range(6, 1)),
                       int'($urandom_range(100, 30)));
            finish_copy(-1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
